// File: rtl/control_me.sv
// Sequencing controller for the full-search motion-estimation datapath:
// loads the current block, sweeps the search window and tracks the minimum SAD.
module control_me #(
    parameter int unsigned MACRO_DIM  = 16,
    parameter int unsigned SEARCH_DIM = 48,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned SAD_LAT    = 3,
    localparam int unsigned NUM_POS   = SEARCH_DIM - MACRO_DIM + 1,
    localparam int unsigned CPR_W     = $clog2(MACRO_DIM),
    localparam int unsigned ROW_W     = $clog2(SEARCH_DIM),
    localparam int unsigned MV_W      = $clog2(NUM_POS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      sad_in,
    output logic [CPR_W-1:0] cpr_addr,
    output logic [ROW_W-1:0] spr_row,
    output logic [ROW_W-1:0] spr_col,
    output logic             sel,
    output logic             en_cpr,
    output logic             en_spr,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [MV_W-1:0]  mv_x,
    output logic [MV_W-1:0]  mv_y,
    output logic [15:0]      best_sad
);

    localparam int unsigned DLY    = MEM_LAT + SAD_LAT;
    localparam int unsigned DCNT_W = $clog2(DLY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CPR_W-1:0]   r_cpr_addr;
    logic [ROW_W-1:0]   r_spr_row;
    logic [ROW_W-1:0]   r_spr_col;
    logic [DCNT_W-1:0]  r_dcnt;
    logic [MEM_LAT:0]   r_cpr_pipe;
    logic [MEM_LAT:0]   r_spr_pipe;
    logic [MEM_LAT:0]   w_cpr_pipe_nxt;
    logic [MEM_LAT:0]   w_spr_pipe_nxt;
    logic [DLY-1:0]     r_tag_v;
    logic [MV_W-1:0]    r_tag_x [DLY];
    logic [MV_W-1:0]    r_tag_y [DLY];
    logic               w_tag_v;
    logic [MV_W-1:0]    w_tag_x;
    logic [MV_W-1:0]    w_tag_y;
    logic               w_last_row;
    logic               w_last_col;
    logic               r_sel;
    logic               r_busy;
    logic               r_done;
    logic [MV_W-1:0]    r_mv_x;
    logic [MV_W-1:0]    r_mv_y;
    logic [15:0]        r_best_sad;

    assign w_last_row = (r_spr_row == ROW_W'(SEARCH_DIM - 1));
    assign w_last_col = (r_spr_col == ROW_W'(NUM_POS - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  if (r_cpr_addr == CPR_W'(MACRO_DIM - 1)) w_state_nxt = S_SWEEP;
            S_SWEEP: if (w_last_row && w_last_col) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_dcnt == DCNT_W'(DLY - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stage 0 of each pipe is the address phase; stage MEM_LAT is the data enable.
    always_comb begin
        w_cpr_pipe_nxt = {r_cpr_pipe[MEM_LAT-1:0], (w_state_nxt == S_LOAD)};
        w_spr_pipe_nxt = {r_spr_pipe[MEM_LAT-1:0], (w_state_nxt == S_SWEEP)};
        w_tag_v        = (r_state == S_SWEEP) && (r_spr_row >= ROW_W'(MACRO_DIM - 1));
        w_tag_x        = MV_W'(r_spr_col);
        w_tag_y        = MV_W'(r_spr_row - ROW_W'(MACRO_DIM - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpr_addr <= '0;
            r_spr_row  <= '0;
            r_spr_col  <= '0;
            r_dcnt     <= '0;
            r_cpr_pipe <= '0;
            r_spr_pipe <= '0;
            r_tag_v    <= '0;
            for (int i = 0; i < DLY; i++) begin
                r_tag_x[i] <= '0;
                r_tag_y[i] <= '0;
            end
            r_sel      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mv_x     <= '0;
            r_mv_y     <= '0;
            r_best_sad <= 16'hFFFF;
        end else begin
            r_cpr_addr <= (r_state == S_LOAD && w_state_nxt == S_LOAD) ?
                          r_cpr_addr + CPR_W'(1) : '0;
            if (r_state == S_SWEEP && w_state_nxt == S_SWEEP) begin
                if (w_last_row) begin
                    r_spr_row <= '0;
                    r_spr_col <= r_spr_col + ROW_W'(1);
                end else begin
                    r_spr_row <= r_spr_row + ROW_W'(1);
                end
            end else begin
                r_spr_row <= '0;
                r_spr_col <= '0;
            end
            r_dcnt     <= (r_state == S_DRAIN) ? r_dcnt + DCNT_W'(1) : '0;
            r_cpr_pipe <= w_cpr_pipe_nxt;
            r_spr_pipe <= w_spr_pipe_nxt;
            r_sel      <= |w_cpr_pipe_nxt;
            r_busy     <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SWEEP) ||
                          (w_state_nxt == S_DRAIN);
            r_done     <= (w_state_nxt == S_DONE);
            // Candidate tags travel through memory and adder-tree latency.
            r_tag_v    <= {r_tag_v[DLY-2:0], w_tag_v};
            r_tag_x[0] <= w_tag_x;
            r_tag_y[0] <= w_tag_y;
            for (int i = 1; i < DLY; i++) begin
                r_tag_x[i] <= r_tag_x[i-1];
                r_tag_y[i] <= r_tag_y[i-1];
            end
            if (r_state == S_IDLE && start) begin
                r_best_sad <= 16'hFFFF;
                r_mv_x     <= '0;
                r_mv_y     <= '0;
            end else if (r_tag_v[DLY-1] && (sad_in < r_best_sad)) begin
                r_best_sad <= sad_in;
                r_mv_x     <= r_tag_x[DLY-1];
                r_mv_y     <= r_tag_y[DLY-1];
            end
        end
    end

    assign cpr_addr = r_cpr_addr;
    assign spr_row  = r_spr_row;
    assign spr_col  = r_spr_col;
    assign sel      = r_sel;
    assign en_cpr   = r_cpr_pipe[MEM_LAT];
    assign en_spr   = r_spr_pipe[MEM_LAT];
    assign valid    = r_tag_v[DLY-1];
    assign busy     = r_busy;
    assign done     = r_done;
    assign mv_x     = r_mv_x;
    assign mv_y     = r_mv_y;
    assign best_sad = r_best_sad;

endmodule

// File: tb/tb_control_me.sv
// Bench for control_me: directed searches with random SAD tables against a
// table-scan minimum model and a cycle schedule derived from the block's timing rules.
module tb_control_me;

    localparam int MD     = 16;
    localparam int SD     = 48;
    localparam int ML     = 1;
    localparam int SL     = 3;
    localparam int NP     = SD - MD + 1;
    localparam int SW     = NP * SD;
    localparam int D      = ML + SL;
    localparam int N_DONE = MD + SW + D + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] sad_in;
    logic [3:0]  cpr_addr;
    logic [5:0]  spr_row;
    logic [5:0]  spr_col;
    logic        sel;
    logic        en_cpr;
    logic        en_spr;
    logic        valid;
    logic        busy;
    logic        done;
    logic [5:0]  mv_x;
    logic [5:0]  mv_y;
    logic [15:0] best_sad;

    int total = 0;
    int bad   = 0;
    logic [15:0] tbl [NP][NP];

    control_me dut (
        .clk(clk), .rst(rst), .start(start), .sad_in(sad_in),
        .cpr_addr(cpr_addr), .spr_row(spr_row), .spr_col(spr_col),
        .sel(sel), .en_cpr(en_cpr), .en_spr(en_spr), .valid(valid),
        .busy(busy), .done(done), .mv_x(mv_x), .mv_y(mv_y), .best_sad(best_sad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cpr_addr"}, 32'(cpr_addr), 32'd0);
        chk({tag, "_spr_row"},  32'(spr_row),  32'd0);
        chk({tag, "_spr_col"},  32'(spr_col),  32'd0);
        chk({tag, "_sel"},      32'(sel),      32'd0);
        chk({tag, "_en_cpr"},   32'(en_cpr),   32'd0);
        chk({tag, "_en_spr"},   32'(en_spr),   32'd0);
        chk({tag, "_valid"},    32'(valid),    32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_mv_x"},     32'(mv_x),     32'd0);
        chk({tag, "_mv_y"},     32'(mv_y),     32'd0);
        chk({tag, "_best_sad"}, 32'(best_sad), 32'hFFFF);
    endtask

    // SAD table indexed [x][y]
    task automatic fill(input int mode);
        for (int x = 0; x < NP; x++)
            for (int y = 0; y < NP; y++)
                case (mode)
                    0:       tbl[x][y] = 16'd1000;
                    1:       tbl[x][y] = 16'd50;
                    3:       tbl[x][y] = 16'hFFFF;
                    4:       tbl[x][y] = 16'($urandom_range(0, 15));
                    default: tbl[x][y] = 16'($urandom);
                endcase
        if (mode == 0) tbl[5][7] = 16'd12;
        if (mode == 1) begin
            tbl[3][3]  = 16'd20;
            tbl[0][10] = 16'd20;
        end
    endtask

    // Column-major scan, strict less-than, starting from FFFF at (0,0)
    task automatic model(output logic [5:0] ex, output logic [5:0] ey, output logic [15:0] eb);
        eb = 16'hFFFF;
        ex = '0;
        ey = '0;
        for (int x = 0; x < NP; x++)
            for (int y = 0; y < NP; y++)
                if (tbl[x][y] < eb) begin
                    eb = tbl[x][y];
                    ex = 6'(x);
                    ey = 6'(y);
                end
    endtask

    // Called and returning at a falling edge with the DUT idle.
    task automatic run_search(input int mode, input string name, input bit extra_starts,
                              input bit start_in_done, input int abort_n);
        int nval, ndone, ncpr, nspr, first_spr, first_val, errcyc, k, m, a;
        logic [5:0]  ex, ey;
        logic [15:0] eb;
        logic        e_busy, e_done, e_sel, e_cpr, e_spr, e_val;
        nval = 0; ndone = 0; ncpr = 0; nspr = 0;
        first_spr = -1; first_val = -1; errcyc = 0; k = 0;
        fill(mode);
        model(ex, ey, eb);
        start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= N_DONE; n++) begin
            if (n == 1) chk({name, "_busy_rise"}, 32'(busy), 32'd1);
            if (n == abort_n) begin
                chk({name, "_col_at_abort"}, 32'(spr_col), 32'd12);
                rst = 1'b1;
                @(negedge clk);
                chk_reset({name, "_abort"});
                rst = 1'b0;
                for (int i = 0; i < 30; i++) begin
                    sad_in = 16'($urandom);
                    @(negedge clk);
                    if (valid || done || busy) errcyc++;
                end
                chk({name, "_quiet_after_rst"}, 32'(errcyc), 32'd0);
                return;
            end
            e_busy = (n < N_DONE);
            e_done = (n == N_DONE);
            e_sel  = (n <= MD + ML);
            e_cpr  = (n >= 1 + ML) && (n <= MD + ML);
            e_spr  = (n >= MD + 1 + ML) && (n < MD + 1 + ML + SW);
            m      = n - (MD + 1) - D;
            e_val  = (m >= 0) && (m < SW) && ((m % SD) >= MD - 1);
            if (busy !== e_busy || done !== e_done || sel !== e_sel || en_cpr !== e_cpr ||
                en_spr !== e_spr || valid !== e_val) errcyc++;
            if (n <= MD && 32'(cpr_addr) != 32'(n - 1)) errcyc++;
            a = n - (MD + 1);
            if (a >= 0 && a < SW &&
                (32'(spr_row) != 32'(a % SD) || 32'(spr_col) != 32'(a / SD))) errcyc++;
            if (en_cpr) ncpr++;
            if (en_spr) begin
                nspr++;
                if (first_spr < 0) first_spr = n;
            end
            if (done) ndone++;
            if (valid) begin
                nval++;
                if (first_val < 0) first_val = n;
                sad_in = (k < NP * NP) ? tbl[k / NP][k % NP] : 16'($urandom);
                k++;
            end else begin
                sad_in = 16'($urandom);
            end
            start = extra_starts && (n == 5 || n == 300);
            if (start_in_done && n == N_DONE) start = 1'b1;
            if (n != N_DONE) @(negedge clk);
        end
        chk({name, "_sched"},     32'(errcyc), 32'd0);
        chk({name, "_n_valid"},   32'(nval),   32'(NP * NP));
        chk({name, "_n_done"},    32'(ndone),  32'd1);
        chk({name, "_n_en_cpr"},  32'(ncpr),   32'(MD));
        chk({name, "_n_en_spr"},  32'(nspr),   32'(SW));
        chk({name, "_lat_00"},    32'(first_val), 32'(first_spr + MD - 1 + SL));
        chk({name, "_mv_x"},      32'(mv_x),     32'(ex));
        chk({name, "_mv_y"},      32'(mv_y),     32'(ey));
        chk({name, "_best_sad"},  32'(best_sad), 32'(eb));
        @(negedge clk);
        start = 1'b0;
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({name, "_hold"},      {4'd0, mv_x, mv_y, best_sad}, {4'd0, ex, ey, eb});
        if (start_in_done) begin
            @(negedge clk);
            chk({name, "_done_start_ignored"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sad_in = '0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        run_search(0, "single",   1'b0, 1'b0, -1);
        run_search(1, "tie",      1'b0, 1'b0, -1);
        run_search(2, "dblstart", 1'b1, 1'b0, -1);
        run_search(3, "allffff",  1'b0, 1'b1, -1);
        run_search(4, "smallsad", 1'b0, 1'b0, -1);
        run_search(2, "abort",    1'b0, 1'b0, MD + 1 + 12 * SD + 5);
        run_search(2, "afterrst", 1'b0, 1'b0, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
